// File: rtl/uart_pkg.sv
// Shared constants for the UART frame decoder: FSM state encoding,
// frame sync byte and error-cause codes.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHK     = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hAA;

  localparam logic [1:0] ERR_TIMEOUT = 2'b00;
  localparam logic [1:0] ERR_CHKSUM  = 2'b01;
  localparam logic [1:0] ERR_LENGTH  = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

endpackage

// File: rtl/uart_frame_decoder.sv
// Decodes AA/CMD/LEN/PAYLOAD/CHK frames from a byte-level UART receiver
// and holds the last good frame until the consumer acknowledges it.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | hunting for the sync byte, other bytes silently dropped
// ST_CMD     | next byte is the command, seeds the XOR checksum
// ST_LEN     | next byte is the payload length (0..MaxLen)
// ST_PAYLOAD | collecting payload bytes into the working buffer
// ST_CHK     | next byte is compared against the running checksum
module uart_frame_decoder
  import uart_pkg::*;
#(
  parameter int ClkFrequency  = 100000000,
  parameter int MaxLen        = 8,
  parameter int TimeoutCycles = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Rx_done,
  input  logic [7:0]            RxD_data,
  output logic                  frame_valid,
  input  logic                  frame_ack,
  output logic [7:0]            frame_cmd,
  output logic [3:0]            frame_len,
  output logic [8*MaxLen-1:0]   frame_payload,
  output logic                  frame_err,
  output logic [1:0]            err_code
);

  localparam int CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);

  // The 4-bit length output bounds the payload size.
  if (ClkFrequency <= 0 || MaxLen < 1 || MaxLen > 15) begin : g_param_check
    $error("uart_frame_decoder: illegal parameter set");
  end

  state_e                state_q, state_d;
  logic                  rx_d1_q;
  logic                  stb_q;
  logic [7:0]            byte_q;
  logic [7:0]            cmd_q, cmd_d;
  logic [3:0]            len_q, len_d;
  logic [3:0]            idx_q, idx_d;
  logic [7:0]            chk_q, chk_d;
  logic [8*MaxLen-1:0]   buf_q, buf_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  fvalid_q, fvalid_d;
  logic [7:0]            fcmd_q, fcmd_d;
  logic [3:0]            flen_q, flen_d;
  logic [8*MaxLen-1:0]   fpay_q, fpay_d;
  logic                  err_q, err_d;
  logic [1:0]            code_q, code_d;
  logic                  publish;
  logic                  timeout;

  // Edge detect on Rx_done; the byte is acted on the cycle after the rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_d1_q <= 1'b1;
      stb_q   <= 1'b0;
      byte_q  <= '0;
    end else begin
      rx_d1_q <= Rx_done;
      stb_q   <= Rx_done & ~rx_d1_q;
      byte_q  <= RxD_data;
    end
  end

  // State, working frame and published-frame registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      chk_q    <= '0;
      buf_q    <= '0;
      cnt_q    <= '0;
      fvalid_q <= 1'b0;
      fcmd_q   <= '0;
      flen_q   <= '0;
      fpay_q   <= '0;
      err_q    <= 1'b0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      chk_q    <= chk_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      fvalid_q <= fvalid_d;
      fcmd_q   <= fcmd_d;
      flen_q   <= flen_d;
      fpay_q   <= fpay_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  // Next-state, frame assembly, timeout and publish/ack handling.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    len_d    = len_q;
    idx_d    = idx_q;
    chk_d    = chk_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    fvalid_d = fvalid_q;
    fcmd_d   = fcmd_q;
    flen_d   = flen_q;
    fpay_d   = fpay_q;
    err_d    = 1'b0;
    code_d   = code_q;
    publish  = 1'b0;

    // Idle counter only matters inside a frame; it saturates at the limit.
    if (state_q == ST_IDLE || stb_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
    timeout = (state_q != ST_IDLE) && !stb_q && (cnt_q == CntMax);

    case (state_q)
      ST_IDLE: begin
        if (stb_q && byte_q == SYNC_BYTE) begin
          state_d = ST_CMD;
          buf_d   = '0;
          idx_d   = '0;
        end
      end
      ST_CMD: begin
        if (stb_q) begin
          cmd_d   = byte_q;
          chk_d   = byte_q;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (stb_q) begin
          chk_d = chk_q ^ byte_q;
          if (byte_q > 8'(MaxLen)) begin
            err_d   = 1'b1;
            code_d  = ERR_LENGTH;
            state_d = ST_IDLE;
          end else if (byte_q == 8'd0) begin
            len_d   = '0;
            state_d = ST_CHK;
          end else begin
            len_d   = byte_q[3:0];
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (stb_q) begin
          chk_d = chk_q ^ byte_q;
          for (int i = 0; i < MaxLen; i++) begin
            if (idx_q == 4'(i)) buf_d[8*i +: 8] = byte_q;
          end
          idx_d = idx_q + 1'b1;
          if (idx_q + 4'd1 == len_q) state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (stb_q) begin
          if (byte_q == chk_q) begin
            publish = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CHKSUM;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout) begin
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
      state_d = ST_IDLE;
    end

    // An ack in the same cycle as a publish frees the slot for the new frame.
    if (publish) begin
      if (fvalid_q && !frame_ack) begin
        err_d  = 1'b1;
        code_d = ERR_OVERRUN;
      end else begin
        fvalid_d = 1'b1;
        fcmd_d   = cmd_q;
        flen_d   = len_q;
        fpay_d   = buf_q;
      end
    end else if (fvalid_q && frame_ack) begin
      fvalid_d = 1'b0;
    end
  end

  assign frame_valid   = fvalid_q;
  assign frame_cmd     = fcmd_q;
  assign frame_len     = flen_q;
  assign frame_payload = fpay_q;
  assign frame_err     = err_q;
  assign err_code      = code_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed plus randomized frames against a frame-level reference model.
module tb_uart_frame_decoder;

  localparam int MaxLen = 8;
  localparam int TO     = 60;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                Rx_done = 1'b0;
  logic [7:0]          RxD_data = 8'h00;
  logic                frame_ack = 1'b0;
  logic                frame_valid;
  logic [7:0]          frame_cmd;
  logic [3:0]          frame_len;
  logic [8*MaxLen-1:0] frame_payload;
  logic                frame_err;
  logic [1:0]          err_code;

  uart_frame_decoder #(
    .ClkFrequency (100000000),
    .MaxLen       (MaxLen),
    .TimeoutCycles(TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Rx_done      (Rx_done),
    .RxD_data     (RxD_data),
    .frame_valid  (frame_valid),
    .frame_ack    (frame_ack),
    .frame_cmd    (frame_cmd),
    .frame_len    (frame_len),
    .frame_payload(frame_payload),
    .frame_err    (frame_err),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int err_pulses = 0;

  always @(negedge clk) if (frame_err === 1'b1) err_pulses++;

  // Reference model: the frame currently held and the error history.
  bit          m_valid = 0;
  logic [7:0]  m_cmd = 0;
  logic [3:0]  m_len = 0;
  logic [63:0] m_pay = 0;
  int          m_errs = 0;
  logic [1:0]  m_code = 2'b00;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".valid"}, 64'(frame_valid), 64'(m_valid));
    check({tag, ".errs"}, 64'(err_pulses), 64'(m_errs));
    check({tag, ".code"}, 64'(err_code), 64'(m_code));
    if (m_valid) begin
      check({tag, ".cmd"}, 64'(frame_cmd), 64'(m_cmd));
      check({tag, ".len"}, 64'(frame_len), 64'(m_len));
      check({tag, ".pay"}, 64'(frame_payload), m_pay);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ack_pub = 0);
    @(posedge clk); #1 RxD_data = b; Rx_done = 1'b1;
    @(posedge clk); #1 frame_ack = ack_pub;
    @(posedge clk); #1 frame_ack = 1'b0;
    @(posedge clk); #1 Rx_done = 1'b0;
    repeat ($urandom_range(2, 5)) @(posedge clk);
    #1;
  endtask

  task automatic do_ack();
    @(posedge clk); #1 frame_ack = 1'b1;
    @(posedge clk); #1 frame_ack = 1'b0;
    m_valid = 0;
  endtask

  // Sends a whole frame and updates the model from the frame-level rules.
  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] lenb,
                           input logic [63:0] pay, input logic [7:0] flip,
                           input bit ack_same = 0);
    logic [7:0]  chk;
    logic [63:0] used;
    send_byte(8'hAA);
    send_byte(cmd);
    send_byte(lenb);
    if (lenb > MaxLen) begin
      m_errs++;
      m_code = 2'b10;
      return;
    end
    chk  = cmd ^ lenb;
    used = '0;
    for (int i = 0; i < int'(lenb); i++) begin
      send_byte(pay[8*i +: 8]);
      chk ^= pay[8*i +: 8];
      used[8*i +: 8] = pay[8*i +: 8];
    end
    send_byte(chk ^ flip, ack_same);
    if (flip != 8'h00) begin
      m_errs++;
      m_code = 2'b01;
    end else if (m_valid && !ack_same) begin
      m_errs++;
      m_code = 2'b11;
    end else begin
      m_valid = 1;
      m_cmd   = cmd;
      m_len   = lenb[3:0];
      m_pay   = used;
    end
  endtask

  initial begin
    int n;
    int e0;
    int kind;
    logic [7:0]  b;
    logic [63:0] rp;

    repeat (3) @(posedge clk);
    #1;
    check("rst.valid", 64'(frame_valid), 64'd0);
    check("rst.err", 64'(frame_err), 64'd0);
    check("rst.code", 64'(err_code), 64'd0);
    check("rst.cmd", 64'(frame_cmd), 64'd0);
    check("rst.len", 64'(frame_len), 64'd0);
    check("rst.pay", 64'(frame_payload), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic two-byte payload frame, then ack.
    run_frame(8'h10, 8'd2, 64'h2211, 8'h00);
    check("f34.pay16", 64'(frame_payload[15:0]), 64'h2211);
    check_state("f34");
    do_ack();
    check_state("f34.ack");

    // Zero-length frame; valid holds until ack, clears right after.
    run_frame(8'h05, 8'd0, 64'h0, 8'h00);
    check_state("f35");
    repeat (4) @(posedge clk);
    #1 check("f35.hold", 64'(frame_valid), 64'd1);
    do_ack();
    check("f35.ackclr", 64'(frame_valid), 64'd0);

    // Ack with nothing held is ignored.
    do_ack();
    check_state("ack_empty");

    // Bad checksum.
    run_frame(8'h10, 8'd1, 64'h33, 8'h33 ^ 8'h10 ^ 8'h01);
    check_state("f36");

    // Over-long length, then a good frame decodes.
    run_frame(8'h10, 8'd9, 64'h0, 8'h00);
    check_state("f37.err");
    run_frame(8'h01, 8'd0, 64'h0, 8'h00);
    check_state("f37.next");
    do_ack();

    // Timeout after AA 10.
    send_byte(8'hAA);
    e0 = err_pulses;
    @(posedge clk); #1 RxD_data = 8'h10; Rx_done = 1'b1;
    n = 0;
    while (err_pulses == e0 && n < TO + 40) begin
      @(negedge clk); #1;
      n++;
      if (n == 3) Rx_done = 1'b0;
    end
    m_errs++;
    m_code = 2'b00;
    check("f38.fired", 64'(err_pulses - e0), 64'd1);
    check("f38.window", 64'(n >= TO && n <= TO + 8), 64'd1);
    check_state("f38");
    run_frame(8'h42, 8'd1, 64'h7E, 8'h00);
    check_state("f38.next");
    do_ack();

    // Overrun: second good frame dropped, first held unchanged.
    run_frame(8'h21, 8'd3, 64'h030201, 8'h00);
    run_frame(8'h22, 8'd2, 64'hBEEF, 8'h00);
    check_state("f39");
    do_ack();

    // Ack coinciding with publish replaces the held frame.
    run_frame(8'h31, 8'd1, 64'h5A, 8'h00);
    run_frame(8'h32, 8'd4, 64'hAA0AA0AA, 8'h00, 1);
    check_state("ack_same");
    do_ack();

    // Sync byte inside a frame is data.
    run_frame(8'hAA, 8'd2, 64'hAAAA, 8'h00);
    check_state("aa_data");
    do_ack();

    // Reset mid-frame with Rx_done high at release.
    send_byte(8'hAA);
    send_byte(8'h10);
    send_byte(8'h02);
    send_byte(8'h11);
    @(posedge clk); #1 RxD_data = 8'h22; Rx_done = 1'b1; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    m_valid = 0;
    m_code  = 2'b00;
    repeat (3) @(posedge clk);
    #1 Rx_done = 1'b0;
    check("mid_rst.cmd", 64'(frame_cmd), 64'd0);
    check("mid_rst.pay", 64'(frame_payload), 64'd0);
    check_state("mid_rst");
    run_frame(8'h66, 8'd1, 64'h99, 8'h00);
    check_state("mid_rst.next");
    do_ack();

    // Randomized frames, garbage and acks.
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 9);
      rp   = {$urandom, $urandom};
      if (kind <= 5) begin
        run_frame(8'($urandom), 8'($urandom_range(0, MaxLen)), rp, 8'h00,
                  ($urandom_range(0, 4) == 0));
      end else if (kind <= 7) begin
        run_frame(8'($urandom), 8'($urandom_range(0, MaxLen)), rp,
                  8'($urandom_range(1, 255)));
      end else if (kind == 8) begin
        run_frame(8'($urandom), 8'($urandom_range(MaxLen + 1, 255)), rp, 8'h00);
      end else begin
        b = 8'($urandom);
        if (b == 8'hAA) b = 8'h55;
        send_byte(b);
      end
      check_state("rand");
      if ($urandom_range(0, 1) == 1) do_ack();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
